// File: rtl/udp_arb_pkg.sv
// Shared types and helpers for the UDP TX arbiter and other shared-resource
// blocks that hand out a path in round-robin order.
//   arb_state_t : arbiter FSM states
//   rr_next     : advance a round-robin pointer, wrapping at n-1 back to 0
package udp_arb_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      GRANT_HDR = 2'd1,
      GRANT_PLD = 2'd2
   } arb_state_t;

   function automatic int rr_next(input int ptr, input int n);
      return (ptr >= n - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin priority search.
// Finds the first asserted request at or after ptr, wrapping modulo N.
//   request     : one bit per requester
//   ptr         : index that gets the highest priority this cycle
//   grant_valid : at least one request is asserted
//   grant_index : winning requester (0 when grant_valid is low)
module rr_arbiter #(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] request,
   input  logic [W-1:0] ptr,
   output logic         grant_valid,
   output logic [W-1:0] grant_index
);

   int cand;

   // Walk the offsets from farthest to nearest so the nearest hit to ptr
   // is the last one written and therefore wins.
   always_comb begin
      grant_valid = 1'b0;
      grant_index = '0;
      cand        = 0;
      for (int k = N - 1; k >= 0; k--) begin
         cand = int'(ptr) + k;
         if (cand >= N) begin
            cand = cand - N;
         end
         if (request[cand[W-1:0]]) begin
            grant_valid = 1'b1;
            grant_index = cand[W-1:0];
         end
      end
   end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Shares one UDP TX path (header + 8-bit payload stream) between NUM_INPUTS
// producers. Round-robin at packet granularity: a grant is held from header
// acceptance until the payload beat carrying tlast.
//   clk, reset          : clock, asynchronous active-high reset
//   in_hdr_*            : per-requester header channel (valid/ready + fields)
//   in_t*               : per-requester payload stream
//   out_hdr_*           : header channel to the UDP TX stack
//   out_t*              : payload stream to the UDP TX stack
//   busy                : a packet is in progress
//   grant_idx           : current or most recent grantee
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no grant; arbitrate among header requests from rr_ptr
// GRANT_HDR | grantee's header routed to output until accepted
// GRANT_PLD | grantee's payload routed to output until tlast handshake
module udp_tx_arbiter
   import udp_arb_pkg::*;
#(
   parameter  int NUM_INPUTS = 4,
   localparam int IDX_WIDTH  = $clog2(NUM_INPUTS)
) (
   input  logic                  clk,
   input  logic                  reset,

   input  logic [NUM_INPUTS-1:0] in_hdr_valid,
   output logic [NUM_INPUTS-1:0] in_hdr_ready,
   input  logic [5:0]            in_ip_dscp      [NUM_INPUTS],
   input  logic [1:0]            in_ip_ecn       [NUM_INPUTS],
   input  logic [7:0]            in_ip_ttl       [NUM_INPUTS],
   input  logic [31:0]           in_ip_source_ip [NUM_INPUTS],
   input  logic [31:0]           in_ip_dest_ip   [NUM_INPUTS],
   input  logic [15:0]           in_source_port  [NUM_INPUTS],
   input  logic [15:0]           in_dest_port    [NUM_INPUTS],
   input  logic [15:0]           in_length       [NUM_INPUTS],
   input  logic [15:0]           in_checksum     [NUM_INPUTS],

   input  logic [7:0]            in_tdata        [NUM_INPUTS],
   input  logic [NUM_INPUTS-1:0] in_tvalid,
   output logic [NUM_INPUTS-1:0] in_tready,
   input  logic [NUM_INPUTS-1:0] in_tlast,
   input  logic [NUM_INPUTS-1:0] in_tuser,

   output logic                  out_hdr_valid,
   input  logic                  out_hdr_ready,
   output logic [5:0]            out_ip_dscp,
   output logic [1:0]            out_ip_ecn,
   output logic [7:0]            out_ip_ttl,
   output logic [31:0]           out_ip_source_ip,
   output logic [31:0]           out_ip_dest_ip,
   output logic [15:0]           out_source_port,
   output logic [15:0]           out_dest_port,
   output logic [15:0]           out_length,
   output logic [15:0]           out_checksum,

   output logic [7:0]            out_tdata,
   output logic                  out_tvalid,
   input  logic                  out_tready,
   output logic                  out_tlast,
   output logic                  out_tuser,

   output logic                  busy,
   output logic [IDX_WIDTH-1:0]  grant_idx
);

   arb_state_t           state;
   logic [IDX_WIDTH-1:0] rr_ptr;
   logic                 arb_valid;
   logic [IDX_WIDTH-1:0] arb_index;

   // Only header valid counts as a request; payload valid alone never wins.
   rr_arbiter #(
      .N (NUM_INPUTS),
      .W (IDX_WIDTH)
   ) u_rr (
      .request     (in_hdr_valid),
      .ptr         (rr_ptr),
      .grant_valid (arb_valid),
      .grant_index (arb_index)
   );

   // Data fields follow grant_idx unconditionally; only valid/ready are
   // gated by state, so an async reset drops every handshake at once.
   always_comb begin
      out_ip_dscp      = in_ip_dscp[grant_idx];
      out_ip_ecn       = in_ip_ecn[grant_idx];
      out_ip_ttl       = in_ip_ttl[grant_idx];
      out_ip_source_ip = in_ip_source_ip[grant_idx];
      out_ip_dest_ip   = in_ip_dest_ip[grant_idx];
      out_source_port  = in_source_port[grant_idx];
      out_dest_port    = in_dest_port[grant_idx];
      out_length       = in_length[grant_idx];
      out_checksum     = in_checksum[grant_idx];
      out_tdata        = in_tdata[grant_idx];
      out_tlast        = in_tlast[grant_idx];
      out_tuser        = in_tuser[grant_idx];
      out_hdr_valid    = 1'b0;
      out_tvalid       = 1'b0;
      in_hdr_ready     = '0;
      in_tready        = '0;
      case (state)
         GRANT_HDR: begin
            out_hdr_valid           = in_hdr_valid[grant_idx];
            in_hdr_ready[grant_idx] = out_hdr_ready;
         end
         GRANT_PLD: begin
            out_tvalid           = in_tvalid[grant_idx];
            in_tready[grant_idx] = out_tready;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         grant_idx <= '0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (arb_valid) begin
                  grant_idx <= arb_index;
                  busy      <= 1'b1;
                  state     <= GRANT_HDR;
               end
            end
            GRANT_HDR: begin
               if (out_hdr_valid && out_hdr_ready) begin
                  state <= GRANT_PLD;
               end
            end
            GRANT_PLD: begin
               if (out_tvalid && out_tready && out_tlast) begin
                  // Pointer moves past the grantee before the next IDLE
                  // arbitration, giving one idle cycle between packets.
                  rr_ptr <= IDX_WIDTH'(rr_next(int'(grant_idx), NUM_INPUTS));
                  busy   <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
module tb_udp_tx_arbiter;

   localparam int NI = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [NI-1:0] in_hdr_valid, in_hdr_ready;
   logic [5:0]    in_ip_dscp      [NI];
   logic [1:0]    in_ip_ecn       [NI];
   logic [7:0]    in_ip_ttl       [NI];
   logic [31:0]   in_ip_source_ip [NI];
   logic [31:0]   in_ip_dest_ip   [NI];
   logic [15:0]   in_source_port  [NI];
   logic [15:0]   in_dest_port    [NI];
   logic [15:0]   in_length       [NI];
   logic [15:0]   in_checksum     [NI];
   logic [7:0]    in_tdata        [NI];
   logic [NI-1:0] in_tvalid, in_tready, in_tlast, in_tuser;

   logic          out_hdr_valid, out_hdr_ready;
   logic [5:0]    out_ip_dscp;
   logic [1:0]    out_ip_ecn;
   logic [7:0]    out_ip_ttl;
   logic [31:0]   out_ip_source_ip, out_ip_dest_ip;
   logic [15:0]   out_source_port, out_dest_port, out_length, out_checksum;
   logic [7:0]    out_tdata;
   logic          out_tvalid, out_tready, out_tlast, out_tuser;
   logic          busy;
   logic [1:0]    grant_idx;

   udp_tx_arbiter #(.NUM_INPUTS(NI)) dut (
      .clk(clk), .reset(reset),
      .in_hdr_valid(in_hdr_valid), .in_hdr_ready(in_hdr_ready),
      .in_ip_dscp(in_ip_dscp), .in_ip_ecn(in_ip_ecn), .in_ip_ttl(in_ip_ttl),
      .in_ip_source_ip(in_ip_source_ip), .in_ip_dest_ip(in_ip_dest_ip),
      .in_source_port(in_source_port), .in_dest_port(in_dest_port),
      .in_length(in_length), .in_checksum(in_checksum),
      .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tready(in_tready),
      .in_tlast(in_tlast), .in_tuser(in_tuser),
      .out_hdr_valid(out_hdr_valid), .out_hdr_ready(out_hdr_ready),
      .out_ip_dscp(out_ip_dscp), .out_ip_ecn(out_ip_ecn), .out_ip_ttl(out_ip_ttl),
      .out_ip_source_ip(out_ip_source_ip), .out_ip_dest_ip(out_ip_dest_ip),
      .out_source_port(out_source_port), .out_dest_port(out_dest_port),
      .out_length(out_length), .out_checksum(out_checksum),
      .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready),
      .out_tlast(out_tlast), .out_tuser(out_tuser),
      .busy(busy), .grant_idx(grant_idx)
   );

   typedef struct {
      logic [5:0]  dscp;
      logic [1:0]  ecn;
      logic [7:0]  ttl;
      logic [31:0] sip, dip;
      logic [15:0] sport, dport, len, csum;
      logic [63:0] data;   // byte b at [8*b +: 8]
      logic [7:0]  user;   // tuser for beat b at bit b
      int          nb;
      int          gap;    // idle cycles before the header is raised
   } pkt_t;

   pkt_t tx_q  [NI][$];    // what each requester still has to send
   pkt_t exp_q [NI][$];    // what the output must still carry per requester

   int   d_phase [NI];
   int   d_gap   [NI];
   int   d_beat  [NI];
   bit   d_hdr_done [NI];
   logic [NI-1:0] hh, ph;

   int   p_tvalid, p_tready, p_hready, cyc;
   bit   pat_mode;
   logic [3:0] pat;

   // Transaction-level reference: pointer, last grantee, packet in flight.
   int   m_ptr, m_gidx, cur, m_beat, bytes_out;
   bit   m_hdr_done, arb_pending;
   logic [NI-1:0] arb_req;
   int   gq[$];

   int   n_tests, n_fail;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int rr_pick(input logic [NI-1:0] req, input int ptr);
      for (int k = 0; k < NI; k++) begin
         int idx;
         idx = (ptr + k) % NI;
         if (req[idx[1:0]]) return idx;
      end
      return -1;
   endfunction

   function automatic int order_code();
      int c = 0;
      foreach (gq[k]) c = c * 16 + gq[k] + 1;
      return c;
   endfunction

   function automatic pkt_t mk_pkt(input int nb, input int gap);
      pkt_t p;
      p.dscp  = 6'($urandom);   p.ecn  = 2'($urandom);  p.ttl = 8'($urandom);
      p.sip   = $urandom;       p.dip  = $urandom;
      p.sport = 16'($urandom);  p.dport = 16'($urandom);
      p.len   = 16'($urandom);  p.csum  = 16'($urandom);
      p.data  = {$urandom, $urandom};
      p.user  = 8'($urandom);
      p.nb    = nb;
      p.gap   = gap;
      return p;
   endfunction

   task automatic push_pkt(input int i, input pkt_t p);
      tx_q[i].push_back(p);
      exp_q[i].push_back(p);
   endtask

   task automatic clear_tb();
      for (int i = 0; i < NI; i++) begin
         in_hdr_valid[i] = 1'b0; in_tvalid[i] = 1'b0;
         in_tlast[i] = 1'b0;     in_tuser[i] = 1'b0;   in_tdata[i] = '0;
         in_ip_dscp[i] = '0;     in_ip_ecn[i] = '0;    in_ip_ttl[i] = '0;
         in_ip_source_ip[i] = '0; in_ip_dest_ip[i] = '0;
         in_source_port[i] = '0; in_dest_port[i] = '0;
         in_length[i] = '0;      in_checksum[i] = '0;
         tx_q[i].delete();       exp_q[i].delete();
         d_phase[i] = 0; d_gap[i] = -1; d_beat[i] = 0; d_hdr_done[i] = 0;
      end
      out_hdr_ready = 1'b0; out_tready = 1'b0;
      hh = '0; ph = '0;
      m_ptr = 0; m_gidx = 0; cur = -1; m_beat = 0;
      m_hdr_done = 0; arb_pending = 0; arb_req = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_tb();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst_valid_busy", {out_hdr_valid, out_tvalid, busy}, 0);
      check_eq("rst_readies", {in_hdr_ready, in_tready}, 0);
      check_eq("rst_gidx", grant_idx, 0);
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic present(input int i);
      pkt_t p;
      int   b;
      p = tx_q[i][0];
      b = d_beat[i];
      in_tvalid[i] = (int'($urandom_range(99)) < p_tvalid);
      in_tdata[i]  = p.data[8*b +: 8];
      in_tlast[i]  = (b == p.nb - 1);
      in_tuser[i]  = p.user[b];
   endtask

   task automatic drive_inputs();
      for (int i = 0; i < NI; i++) begin
         if (d_phase[i] == 1) begin
            if (hh[i]) begin
               in_hdr_valid[i] = 1'b0;
               d_hdr_done[i]   = 1;
            end
            if (ph[i]) d_beat[i]++;
            if (d_hdr_done[i] && d_beat[i] >= tx_q[i][0].nb) begin
               void'(tx_q[i].pop_front());
               in_tvalid[i] = 1'b0;
               in_tlast[i]  = 1'b0;
               d_phase[i]   = 0;
            end else if (d_beat[i] < tx_q[i][0].nb && !(in_tvalid[i] && !ph[i])) begin
               present(i);
            end
         end
         if (d_phase[i] == 0 && tx_q[i].size() > 0) begin
            if (d_gap[i] < 0) d_gap[i] = tx_q[i][0].gap;
            if (d_gap[i] == 0) begin
               pkt_t p;
               p = tx_q[i][0];
               in_ip_dscp[i] = p.dscp;      in_ip_ecn[i] = p.ecn;  in_ip_ttl[i] = p.ttl;
               in_ip_source_ip[i] = p.sip;  in_ip_dest_ip[i] = p.dip;
               in_source_port[i] = p.sport; in_dest_port[i] = p.dport;
               in_length[i] = p.len;        in_checksum[i] = p.csum;
               in_hdr_valid[i] = 1'b1;
               d_phase[i] = 1; d_gap[i] = -1; d_beat[i] = 0; d_hdr_done[i] = 0;
               present(i);
            end else begin
               d_gap[i]--;
            end
         end
      end
   endtask

   task automatic monitor();
      logic [NI-1:0] one_hot;
      bit   idle_now;
      pkt_t p;
      hh = in_hdr_valid & in_hdr_ready;
      ph = in_tvalid & in_tready;
      if (cur < 0) begin
         check_eq("hdr_valid_timing", out_hdr_valid, arb_pending);
         if (out_hdr_valid) begin
            cur = rr_pick(arb_req, m_ptr);
            if (cur < 0) cur = int'(grant_idx);
            m_gidx = cur; m_hdr_done = 0; m_beat = 0;
            gq.push_back(cur);
            if (exp_q[cur].size() == 0) begin
               check_eq("pkt_expected", 0, 1);
            end else begin
               p = exp_q[cur][0];
               check_eq("hdr_ips", {out_ip_source_ip, out_ip_dest_ip}, {p.sip, p.dip});
               check_eq("hdr_ports", {out_source_port, out_dest_port, out_length, out_checksum},
                        {p.sport, p.dport, p.len, p.csum});
               check_eq("hdr_misc", {out_ip_dscp, out_ip_ecn, out_ip_ttl}, {p.dscp, p.ecn, p.ttl});
            end
         end
      end
      idle_now = (cur < 0);
      check_eq("busy", busy, !idle_now);
      check_eq("grant_idx", grant_idx, m_gidx);
      one_hot = NI'(1) << (idle_now ? 0 : cur);
      if (idle_now) begin
         check_eq("idle_quiet", {out_tvalid, in_hdr_ready, in_tready}, 0);
      end else if (!m_hdr_done) begin
         check_eq("hdr_valid_hold", out_hdr_valid, 1);
         check_eq("hdr_ready_route", in_hdr_ready, out_hdr_ready ? one_hot : '0);
         check_eq("hdr_phase_no_pld", {out_tvalid, in_tready}, 0);
         if (out_hdr_valid && out_hdr_ready) m_hdr_done = 1;
      end else begin
         check_eq("pld_no_hdr", {out_hdr_valid, in_hdr_ready}, 0);
         check_eq("tready_route", in_tready, out_tready ? one_hot : '0);
         check_eq("tvalid_route", out_tvalid, in_tvalid[cur]);
         if (out_tvalid && out_tready) begin
            if (exp_q[cur].size() == 0) begin
               check_eq("pld_expected", 0, 1);
            end else begin
               p = exp_q[cur][0];
               check_eq("pld_beat", {out_tuser, out_tlast, out_tdata},
                        {p.user[m_beat], m_beat == p.nb - 1, p.data[8*m_beat +: 8]});
            end
            m_beat++;
            bytes_out++;
            if (out_tlast) begin
               if (exp_q[cur].size() > 0) void'(exp_q[cur].pop_front());
               m_ptr = (cur + 1) % NI;
               cur   = -1;
            end
         end
      end
      arb_pending = idle_now && (in_hdr_valid != '0);
      arb_req     = in_hdr_valid;
   endtask

   task automatic step();
      @(negedge clk);
      monitor();
      @(posedge clk); #1;
      cyc++;
      out_hdr_ready = (int'($urandom_range(99)) < p_hready);
      out_tready    = pat_mode ? pat[cyc % 4] : (int'($urandom_range(99)) < p_tready);
      drive_inputs();
   endtask

   function automatic bit all_done();
      for (int i = 0; i < NI; i++)
         if (tx_q[i].size() != 0 || exp_q[i].size() != 0) return 0;
      return cur < 0;
   endfunction

   task automatic run_pkts(input string tag, input int budget);
      int n = 0;
      while (!all_done() && n < budget) begin
         step();
         n++;
      end
      check_eq(tag, all_done(), 1);
   endtask

   initial begin
      pkt_t p;
      int   b0, total, n;
      n_tests = 0; n_fail = 0; cyc = 0; bytes_out = 0;
      p_tvalid = 100; p_tready = 100; p_hready = 100;
      pat_mode = 0; pat = 4'b1001;
      do_reset();

      // Single requester on input 2.
      p = mk_pkt(4, 0);
      p.dport = 16'd1234; p.len = 16'd12;
      p.data  = 64'h0000_0000_EFBE_ADDE;
      push_pkt(2, p);
      gq.delete();
      run_pkts("single_drain", 100);
      check_eq("single_order", order_code(), 'h3);
      step();
      check_eq("single_gidx_idle", grant_idx, 2);

      // Inputs 0 and 3 together from reset, then again after the wrap.
      do_reset();
      gq.delete();
      push_pkt(0, mk_pkt(1 + $urandom_range(3), 0));
      push_pkt(3, mk_pkt(1 + $urandom_range(3), 0));
      run_pkts("simul_drain1", 100);
      push_pkt(0, mk_pkt(1 + $urandom_range(3), 0));
      push_pkt(3, mk_pkt(1 + $urandom_range(3), 0));
      run_pkts("simul_drain2", 100);
      check_eq("simul_order", order_code(), 'h1414);

      // Input 1 raises its header while input 0 is streaming payload.
      gq.delete();
      push_pkt(0, mk_pkt(4, 0));
      push_pkt(1, mk_pkt(3, 3));
      run_pkts("lock_drain", 100);
      check_eq("lock_order", order_code(), 'h12);

      // Output backpressure 1,0,0,1 over a 6-byte payload.
      pat_mode = 1;
      b0 = bytes_out;
      push_pkt(2, mk_pkt(6, 0));
      run_pkts("bp_drain", 100);
      check_eq("bp_bytes", bytes_out - b0, 6);
      pat_mode = 0;

      // All four requesting continuously for eight packets.
      do_reset();
      gq.delete();
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < NI; i++)
            push_pkt(i, mk_pkt(1 + $urandom_range(2), 0));
      run_pkts("rr_drain", 200);
      check_eq("rr_order", order_code(), 'h12341234);

      // Reset during the third beat of a five-beat packet.
      push_pkt(1, mk_pkt(2, 0));
      run_pkts("pre_mid_drain", 50);
      push_pkt(3, mk_pkt(5, 0));
      n = 0;
      while (!(cur == 3 && m_beat == 2) && n < 50) begin
         step();
         n++;
      end
      check_eq("mid_reached", (cur == 3 && m_beat == 2), 1);
      check_eq("mid_tvalid_before", out_tvalid, 1);
      #1 reset = 1'b1;
      #1;
      check_eq("mid_rst_valid", {out_hdr_valid, out_tvalid, busy}, 0);
      check_eq("mid_rst_readies", {in_hdr_ready, in_tready}, 0);
      do_reset();
      gq.delete();
      push_pkt(1, mk_pkt(2, 0));
      push_pkt(3, mk_pkt(2, 0));
      run_pkts("post_rst_drain", 100);
      check_eq("post_rst_order", order_code(), 'h24);

      // Randomized traffic with random stalls on both sides.
      do_reset();
      p_tvalid = 70; p_tready = 70; p_hready = 60;
      b0 = bytes_out; total = 0;
      for (int k = 0; k < 40; k++) begin
         int nb;
         nb = 1 + $urandom_range(5);
         total += nb;
         push_pkt($urandom_range(NI - 1), mk_pkt(nb, $urandom_range(5)));
      end
      run_pkts("rand_drain", 5000);
      check_eq("rand_bytes", bytes_out - b0, total);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1);
   end

endmodule

// File: doc/udp_tx_arbiter.md
Name: udp_tx_arbiter

Overview:
- Shares one UDP TX path (header interface plus payload AXI-Stream) between NUM_INPUTS requesters, e.g. several udp_axis_slave instances.
- Uses round-robin arbitration at packet granularity.
- The grant is held from header acceptance through the payload beat carrying tlast, so header and payload of one packet are never interleaved with another requester's.
- Sits between the UDP producers and the single UDP/IP TX stack.

Parameters:
- NUM_INPUTS, 4, number of requesters; legal range 2..16.
- IDX_WIDTH, $clog2(NUM_INPUTS), width of the grant index. Derived; not overridden.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_header_if  UDP_TX_HEADER_IF slave  [NUM_INPUTS]  requester headers: valid, ready, ip_dscp, ip_ecn, ip_ttl, ip_source_ip, ip_dest_ip, source_port, dest_port, length, checksum.
- in_payload_if  AXIS_IF slave (8-bit tdata, TUSER_WIDTH 1, no tkeep)  [NUM_INPUTS]  requester payloads.
- out_header_if  UDP_TX_HEADER_IF master  1  header to the UDP TX stack.
- out_payload_if  AXIS_IF master (8-bit, TUSER_WIDTH 1, no tkeep)  1  payload to the UDP TX stack.
- busy  output  1  high while in GRANT_HDR or GRANT_PLD.
- grant_idx  output  IDX_WIDTH  index of the current or most recent grantee.

Behaviour:
- Reset values:
  - state=IDLE, rr_ptr=0, grant_idx=0, busy=0.
  - out header valid=0, out tvalid=0.
  - all in header ready=0, all in tready=0.
- Request = in_header_if[i].valid. Payload valid does not count as a request.
- State IDLE:
  - Select the first i with an asserted request, searching i = rr_ptr, rr_ptr+1, ... modulo NUM_INPUTS (wrap-around).
  - Register the winner into grant_idx and go to GRANT_HDR on the next edge.
  - Arbitration latency is 1 cycle: the out header valid is first visible the cycle after the request is seen.
  - With no request, stay in IDLE.
- State GRANT_HDR:
  - out header fields and valid are combinationally muxed from in_header_if[grant_idx].
  - in_header_if[grant_idx].ready = out_header_if.ready. All other header readies = 0.
  - On out valid&&ready, go to GRANT_PLD.
  - No payload beats pass in this state; every in tready = 0 and out tvalid = 0.
- State GRANT_PLD:
  - out tdata/tvalid/tlast/tuser are muxed from in_payload_if[grant_idx].
  - in_payload_if[grant_idx].tready = out tready. All other treadies = 0.
  - All header readies = 0.
  - On out tvalid&&tready&&tlast: rr_ptr <= grant_idx+1 (wrapping to 0 at NUM_INPUTS-1), then go to IDLE.
  - At least 1 idle cycle separates packets. Back-to-back throughput is therefore one packet per (payload beats + 2) cycles minimum.
- Requester hold rules:
  - A requester that drops header valid before acceptance is still held granted.
  - The arbiter waits in GRANT_HDR indefinitely. An AXIS violation by the requester is not guarded against.
- Simultaneous events: a new request arriving in the same cycle as the tlast handshake is not seen until IDLE. The rr_ptr update takes effect before that IDLE arbitration.
- Non-granted requesters see ready=0 and must hold their data (AXIS stall).
- Reset mid-packet:
  - Asynchronous return to IDLE with all valids and readies low immediately.
  - The downstream stack sees a truncated packet with no tlast. This is accepted; system reset covers both sides.
- grant_idx holds its value in IDLE (last grantee).

Decomposition:
- Shared package udp_arb_pkg:
  - typedef enum arb_state_t {IDLE, GRANT_HDR, GRANT_PLD}.
  - function rr_next(ptr, n) implementing the wrap rule.
- Sub-module rr_arbiter:
  - Parameter N. Inputs: request[N], ptr.
  - Outputs: grant_valid, grant_index.
  - Purely combinational priority search from ptr. Reusable by other shared-resource blocks.

Test Plan:
- Single requester: input 2 sends header (dest_port 1234, length 12) plus 4 payload beats 0xDE,0xAD,0xBE,0xEF with tlast → header seen unchanged on output one cycle after valid; payload bytes identical in order; grant_idx=2; busy falls the cycle after tlast.
- Simultaneous requests: inputs 0 and 3 both request from reset → order 0 then 3. Then rr_ptr=0 after wrap; a repeat with 0 and 3 both requesting again grants 0 first.
- Lock: input 1 raises header valid while input 0 is in GRANT_PLD → in_header_if[1].ready stays 0 until input 0's tlast handshake. Input 1 is granted on the following IDLE cycle; no input 1 bytes appear before input 0's tlast.
- Backpressure: out tready toggles 1,0,0,1 during a 6-byte payload → all 6 bytes delivered once, in order; the granted tready mirrors out tready each cycle.
- Round-robin fairness: all 4 inputs request continuously for 8 packets → grant sequence 0,1,2,3,0,1,2,3.
- Reset mid-packet: assert reset during beat 3 of a 5-beat packet → out tvalid and all readies 0 in the same cycle. After release, state is IDLE with rr_ptr=0, and the next request is served normally.
